// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding-select encodings and the NOP instruction word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } ctrl_state_e;

    localparam logic [1:0]  FWD_REG  = 2'b00;
    localparam logic [1:0]  FWD_WB   = 2'b01;
    localparam logic [1:0]  FWD_MEM  = 2'b10;

    localparam logic [15:0] NOP_INST = 16'h1000;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding selects; the MEM stage has priority over WB and
// register 0 is never forwarded.
module forward_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] EX_Rs,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic [REG_ADDR_W-1:0] MEM_Rd,
    input  logic                  MEM_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_Rd,
    input  logic                  WB_RegWrite,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB
);

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we
    );
        logic [1:0] sel;
        if (mem_we && (mem_rd != {REG_ADDR_W{1'b0}}) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != {REG_ADDR_W{1'b0}}) && (wb_rd == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    // Select the forwarding source for both EX operands
    always_comb begin
        fwdA = fwd_sel(EX_Rs, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
        fwdB = fwd_sel(EX_Rt, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register write enables, flush/bubble, forwarding,
// data-memory wait/timeout FSM, halt state and saturating stall counter.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic [REG_ADDR_W-1:0] EX_Rs,
    input  logic [REG_ADDR_W-1:0] EX_Rt,
    input  logic [REG_ADDR_W-1:0] EX_dstReg,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_Rd,
    input  logic                  MEM_RegWrite,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_MemWrite,
    input  logic [REG_ADDR_W-1:0] WB_Rd,
    input  logic                  WB_RegWrite,
    input  logic                  branch_taken,
    input  logic                  dmem_ready,
    input  logic                  halt,
    output logic                  PC_write,
    output logic                  IFID_write,
    output logic                  IDEX_write,
    output logic                  EXMEM_write,
    output logic                  MEMWB_write,
    output logic                  IFID_flush,
    output logic                  IDEX_bubble,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  mem_timeout_err,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              err_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic       mem_busy_s;
    logic       load_use_s;
    logic       stall_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_forward_unit (
        .EX_Rs        (EX_Rs),
        .EX_Rt        (EX_Rt),
        .MEM_Rd       (MEM_Rd),
        .MEM_RegWrite (MEM_RegWrite),
        .WB_Rd        (WB_Rd),
        .WB_RegWrite  (WB_RegWrite),
        .fwdA         (fwd_a_s),
        .fwdB         (fwd_b_s)
    );

    // Hazard detection terms
    always_comb begin
        mem_busy_s = (MEM_MemRead | MEM_MemWrite) & ~dmem_ready;
        load_use_s = EX_MemRead & EX_RegWrite & (EX_dstReg != {REG_ADDR_W{1'b0}}) &
                     ((ID_UsesRs & (EX_dstReg == ID_Rs)) | (ID_UsesRt & (EX_dstReg == ID_Rt)));
        // A cycle counts as a stall only if the freeze or the load-use bubble actually acts
        stall_s    = (state_r != HALTED) &
                     (mem_busy_s | (load_use_s & ~branch_taken));
    end

    // Control outputs act in the same cycle; priority freeze > branch > load-use
    always_comb begin
        PC_write        = 1'b1;
        IFID_write      = 1'b1;
        IDEX_write      = 1'b1;
        EXMEM_write     = 1'b1;
        MEMWB_write     = 1'b1;
        IFID_flush      = 1'b0;
        IDEX_bubble     = 1'b0;
        fwdA            = FWD_REG;
        fwdB            = FWD_REG;
        halted          = 1'b0;
        mem_timeout_err = 1'b0;
        if (!rst) begin
            PC_write = 1'b1;
        end else begin
            fwdA            = fwd_a_s;
            fwdB            = fwd_b_s;
            mem_timeout_err = err_r;
            case (state_r)
                RUN, MEM_WAIT: begin
                    if (mem_busy_s) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_write  = 1'b0;
                        EXMEM_write = 1'b0;
                        MEMWB_write = 1'b0;
                    end else if (branch_taken) begin
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                    end else if (load_use_s) begin
                        PC_write    = 1'b0;
                        IFID_write  = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else begin
                        IDEX_bubble = 1'b0;
                    end
                end
                default: begin
                    PC_write    = 1'b0;
                    IFID_write  = 1'b0;
                    IDEX_write  = 1'b0;
                    EXMEM_write = 1'b0;
                    MEMWB_write = 1'b0;
                    halted      = 1'b1;
                end
            endcase
        end
    end

    // Wait/timeout FSM, sticky error and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= RUN;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            err_r       <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            case (state_r)
                RUN: begin
                    if (mem_busy_s) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else if (halt) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy_s) begin
                        if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                            err_r   <= 1'b1;
                            state_r <= HALTED;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        state_r    <= halt ? HALTED : RUN;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                end
                default: begin
                    state_r <= HALTED;
                end
            endcase
        end
    end

    assign stall_count = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the control rules.
module tb_hazard_ctrl;

    localparam int RW      = 4;
    localparam int TIMEOUT = 15;
    localparam int CW      = 16;

    logic clk = 1'b0;
    logic rst;
    logic [RW-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_dstReg, MEM_Rd, WB_Rd;
    logic ID_UsesRs, ID_UsesRt, EX_RegWrite, EX_MemRead;
    logic MEM_RegWrite, MEM_MemRead, MEM_MemWrite, WB_RegWrite;
    logic branch_taken, dmem_ready, halt;
    logic PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write;
    logic IFID_flush, IDEX_bubble, mem_timeout_err, halted;
    logic [1:0] fwdA, fwdB;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_halted;
    bit m_err;
    int m_busy_run;
    int m_stall;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_dstReg(EX_dstReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready), .halt(halt),
        .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
        .EXMEM_write(EXMEM_write), .MEMWB_write(MEMWB_write),
        .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
        .fwdA(fwdA), .fwdB(fwdB), .mem_timeout_err(mem_timeout_err),
        .halted(halted), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        EX_Rs = '0; EX_Rt = '0; EX_dstReg = '0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
        MEM_Rd = '0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        WB_Rd = '0; WB_RegWrite = 1'b0;
        branch_taken = 1'b0; dmem_ready = 1'b1; halt = 1'b0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [RW-1:0] src);
        if (MEM_RegWrite && MEM_Rd != 0 && MEM_Rd == src) return 2'b10;
        if (WB_RegWrite && WB_Rd != 0 && WB_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Inputs are set at the negedge; check 1 time unit later, then advance the model.
    task automatic step();
        bit busy, lu;
        bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_flush, e_bub, e_halted, e_err;
        logic [1:0] e_fa, e_fb;
        #1;
        busy = (MEM_MemRead || MEM_MemWrite) && !dmem_ready;
        lu   = EX_MemRead && EX_RegWrite && EX_dstReg != 0 &&
               ((ID_UsesRs && EX_dstReg == ID_Rs) || (ID_UsesRt && EX_dstReg == ID_Rt));
        {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
        e_flush = 0; e_bub = 0; e_halted = 0; e_err = 0; e_fa = 2'b00; e_fb = 2'b00;
        if (rst) begin
            e_fa = ref_fwd(EX_Rs);
            e_fb = ref_fwd(EX_Rt);
            e_err = m_err;
            if (m_halted) begin
                {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
                e_halted = 1;
            end else if (busy) begin
                {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b00000;
            end else if (branch_taken) begin
                e_flush = 1; e_bub = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
            end
        end
        chk("PC_write", PC_write, e_pc);
        chk("IFID_write", IFID_write, e_ifid);
        chk("IDEX_write", IDEX_write, e_idex);
        chk("EXMEM_write", EXMEM_write, e_exmem);
        chk("MEMWB_write", MEMWB_write, e_memwb);
        chk("IFID_flush", IFID_flush, e_flush);
        chk("IDEX_bubble", IDEX_bubble, e_bub);
        chk("fwdA", fwdA, e_fa);
        chk("fwdB", fwdB, e_fb);
        chk("halted", halted, e_halted);
        chk("mem_timeout_err", mem_timeout_err, e_err);
        chk("stall_count", stall_count, m_stall);
        if (!rst) begin
            m_halted = 0; m_err = 0; m_busy_run = 0; m_stall = 0;
        end else if (!m_halted) begin
            if ((busy || (lu && !branch_taken)) && m_stall < 65535) m_stall++;
            if (busy) begin
                if (m_busy_run == TIMEOUT) begin
                    m_err = 1; m_halted = 1;
                end else begin
                    m_busy_run++;
                end
            end else begin
                m_busy_run = 0;
                if (halt) m_halted = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_load_use();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_dstReg = 4'd5; ID_Rt = 4'd5; ID_UsesRt = 1'b1;
    endtask

    initial begin
        int burst;
        rst = 1'b0;
        clear_inputs();
        m_halted = 0; m_err = 0; m_busy_run = 0; m_stall = 0;
        @(negedge clk);
        step();
        chk("reset_stall", stall_count, 32'd0);
        rst = 1'b1;

        // Forwarding priority and register 0
        EX_Rs = 4'd3; MEM_Rd = 4'd3; MEM_RegWrite = 1'b1; WB_Rd = 4'd3; WB_RegWrite = 1'b1;
        #1 chk("fwd_mem", fwdA, 32'd2);
        step();
        MEM_Rd = 4'd0;
        #1 chk("fwd_wb", fwdA, 32'd1);
        step();
        EX_Rs = 4'd0;
        #1 chk("fwd_zero", fwdA, 32'd0);
        step();
        clear_inputs();

        // Single load-use bubble
        set_load_use();
        #1 chk("lu_pc", PC_write, 32'd0);
        step();
        clear_inputs();
        #1 chk("lu_stall", stall_count, 32'd1);
        step();

        // Branch wins over load-use
        set_load_use();
        branch_taken = 1'b1;
        #1 chk("br_flush", IFID_flush, 32'd1);
        chk("br_pc", PC_write, 32'd1);
        step();
        clear_inputs();

        // Memory wait of three cycles
        rst = 1'b0; step(); rst = 1'b1;
        MEM_MemRead = 1'b1; dmem_ready = 1'b0;
        repeat (3) step();
        dmem_ready = 1'b1;
        #1 chk("mw_resume", MEMWB_write, 32'd1);
        step();
        clear_inputs();
        #1 chk("mw_stall", stall_count, 32'd3);
        step();

        // Timeout, sticky through a late ready, cleared by reset
        MEM_MemWrite = 1'b1; dmem_ready = 1'b0;
        repeat (TIMEOUT + 1) step();
        #1 chk("to_err", mem_timeout_err, 32'd1);
        chk("to_halted", halted, 32'd1);
        dmem_ready = 1'b1;
        step();
        #1 chk("to_sticky", halted, 32'd1);
        rst = 1'b0; step(); rst = 1'b1;
        clear_inputs();
        #1 chk("to_cleared", mem_timeout_err, 32'd0);
        step();

        // Halt during load-use freezes the counter
        set_load_use();
        halt = 1'b1;
        step();
        clear_inputs();
        set_load_use();
        #1 chk("halt_now", halted, 32'd1);
        repeat (3) step();
        chk("halt_stall", stall_count, 32'd1);

        // Reset in the middle of a memory wait
        rst = 1'b0; step(); rst = 1'b1;
        clear_inputs();
        MEM_MemRead = 1'b1; dmem_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        #1 chk("rst_mw_pc", PC_write, 32'd1);
        rst = 1'b1;
        clear_inputs();
        step();

        // Random traffic against the model
        burst = 0;
        for (int i = 0; i < 1200; i++) begin
            rst = ((i % 200) == 199 || (m_halted && $urandom_range(0, 5) == 0)) ? 1'b0 : 1'b1;
            ID_Rs = 4'($urandom_range(0, 3)); ID_Rt = 4'($urandom_range(0, 3));
            ID_UsesRs = 1'($urandom); ID_UsesRt = 1'($urandom);
            EX_Rs = 4'($urandom_range(0, 3)); EX_Rt = 4'($urandom_range(0, 3));
            EX_dstReg = 4'($urandom_range(0, 3));
            EX_RegWrite = 1'($urandom); EX_MemRead = 1'($urandom);
            MEM_Rd = 4'($urandom_range(0, 3)); MEM_RegWrite = 1'($urandom);
            WB_Rd = 4'($urandom_range(0, 3)); WB_RegWrite = 1'($urandom);
            branch_taken = ($urandom_range(0, 5) == 0);
            halt = ($urandom_range(0, 79) == 0);
            if (burst > 0) begin
                MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; dmem_ready = 1'b0;
                burst--;
            end else begin
                MEM_MemRead = 1'($urandom); MEM_MemWrite = 1'($urandom);
                dmem_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 18);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
